// File: rtl/full_adder_pkg.sv
// Shared width constants for the registered ripple-carry adder.
package full_adder_pkg;
    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MIN_WIDTH     = 1;
    localparam int FA_MAX_WIDTH     = 64;
endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell; chained to form the ripple adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with registered sum/carry and a one-cycle valid.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);
    if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_width_chk
        $error("full_adder: WIDTH must be within 1..64");
    end

    logic [WIDTH:0]   cy;
    logic [WIDTH-1:0] s;

    assign cy[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (cy[i]),
            .s    (s[i]),
            .cout (cy[i+1])
        );
    end

    // Result registers load only on qualified inputs, so unqualified X/Z never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= s;
                carry <= cy[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1/8/16 instances against an arithmetic reference model.
module tb_full_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic        c;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic [0:0]  s1;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        co1, co8, co16;
    logic        ov1, ov8, ov16;

    // reference model state: {carry,sum} per width and shared valid
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [16:0] e16;
    logic        ev;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c), .in_valid(v),
        .sum(s1), .carry(co1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c), .in_valid(v),
        .sum(s8), .carry(co8), .out_valid(ov8)
    );
    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c), .in_valid(v),
        .sum(s16), .carry(co16), .out_valid(ov16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model from the current inputs, clock once, compare every instance.
    task automatic tick(input string tag);
        if (rst) begin
            e1 = '0; e8 = '0; e16 = '0; ev = 1'b0;
        end else begin
            ev = v;
            if (v) begin
                e1  = 2'(a1)   + 2'(b1)   + 2'(c);
                e8  = 9'(a8)   + 9'(b8)   + 9'(c);
                e16 = 17'(a16) + 17'(b16) + 17'(c);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "/w1"},  64'({ov1,  co1,  s1}),  64'({ev, e1}));
        chk({tag, "/w8"},  64'({ov8,  co8,  s8}),  64'({ev, e8}));
        chk({tag, "/w16"}, 64'({ov16, co16, s16}), 64'({ev, e16}));
    endtask

    task automatic rand_inputs();
        a1  = 1'($urandom);  b1  = 1'($urandom);
        a8  = 8'($urandom);  b8  = 8'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom);
        c   = 1'($urandom);
    endtask

    initial begin
        logic [2:0] abc;
        logic [1:0] req027_in  [6];
        logic [1:0] req027_exp [6];
        logic [2:0] tt;
        logic [9:0] hold8;

        // (a,b,c) stimulus and expected (sum,carry) for the directed WIDTH=1 sequence
        req027_in[0] = 2'd0; req027_in[1] = 2'd1; req027_in[2] = 2'd2;
        req027_in[3] = 2'd3; req027_in[4] = 2'd3; req027_in[5] = 2'd2;
        req027_exp[0] = 2'b00; req027_exp[1] = 2'b10; req027_exp[2] = 2'b10;
        req027_exp[3] = 2'b11; req027_exp[4] = 2'b01; req027_exp[5] = 2'b01;

        rst = 1'b1; v = 1'b0;
        rand_inputs();
        tick("reset0");
        tick("reset1");

        // reset wins over a simultaneous qualified input
        a1 = 1'b1; b1 = 1'b1; a8 = 8'h01; b8 = 8'h01; a16 = 16'h1; b16 = 16'h1; c = 1'b1; v = 1'b1;
        tick("rst_prio");
        chk("rst_prio_const", 64'({ov1, s1, co1}), 64'(3'b000));

        // first qualified edge after reset produces a result immediately
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: abc = 3'b000;
                1: abc = 3'b001;
                2: abc = 3'b010;
                3: abc = 3'b111;
                4: abc = 3'b110;
                default: abc = 3'b101;
            endcase
            a1 = abc[2]; b1 = abc[1]; c = abc[0]; v = 1'b1;
            tick("seq027");
            chk("seq027_const", 64'({ov1, s1, co1}), 64'({1'b1, req027_exp[i]}));
        end

        // exhaustive WIDTH=1 truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            tt = 3'(i);
            a1 = tt[2]; b1 = tt[1]; c = tt[0]; v = 1'b1;
            tick("truth");
            chk("truth_popcount", 64'({co1, s1}), 64'(2'(tt[2]) + 2'(tt[1]) + 2'(tt[0])));
        end

        // WIDTH=8 carry boundaries
        a8 = 8'hFF; b8 = 8'h01; c = 1'b0; v = 1'b1;
        tick("w8_ff01");
        chk("w8_ff01_const", 64'({co8, s8}), 64'(9'h100));
        a8 = 8'hFF; b8 = 8'hFF; c = 1'b1;
        tick("w8_ffff1");
        chk("w8_ffff1_const", 64'({co8, s8}), 64'(9'h1FF));

        // WIDTH=16 wrap-around
        a16 = 16'hFFFF; b16 = 16'hFFFF; c = 1'b1;
        tick("w16_all1");
        chk("w16_all1_const", 64'({co16, s16}), 64'(17'h1FFFF));
        a16 = 16'hFFFF; b16 = 16'h0000; c = 1'b1;
        tick("w16_wrap0");
        chk("w16_wrap0_const", 64'({co16, s16}), 64'(17'h10000));

        // hold with in_valid low and changing inputs, including X
        a8 = 8'h3C; b8 = 8'h5A; c = 1'b1; v = 1'b1;
        tick("pre_hold");
        hold8 = {1'b1, e8};
        v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick("hold");
            chk("hold_const", 64'({ov8, co8, s8}), 64'({1'b0, hold8[8:0]}));
        end
        a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x; a16 = 'x; b16 = 'x; c = 1'bx;
        tick("hold_x");

        // mid-stream reset cancels pending results
        rand_inputs(); v = 1'b1;
        tick("pre_mid_rst");
        rand_inputs(); rst = 1'b1;
        tick("mid_rst");
        rst = 1'b0; v = 1'b0; rand_inputs();
        tick("post_mid_rst");
        chk("post_mid_rst_const", 64'({ov16, co16, s16}), 64'(0));

        // random stream with occasional idle cycles
        for (int i = 0; i < 1000; i++) begin
            rand_inputs();
            v = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 a  input  WIDTH  addend A, unsigned.
REQ-005 b  input  WIDTH  addend B, unsigned.
REQ-006 c  input  1  carry-in.
REQ-007 in_valid  input  1  a/b/c are qualified this cycle.
REQ-008 sum  output  WIDTH  registered result bits, LSB-aligned.
REQ-009 carry  output  1  registered carry-out of the MSB position.
REQ-010 out_valid  output  1  sum/carry hold a result computed from a qualified input.

Function
REQ-011 The block SHALL compute {carry, sum} = a + b + c as a WIDTH+1-bit unsigned result; no truncation of the carry.
REQ-012 Per bit i: sum[i] = a[i] XOR b[i] XOR cin_i; cout_i = majority(a[i], b[i], cin_i); cin_0 = c; cin_(i+1) = cout_i; carry = cout_(WIDTH-1).
REQ-013 For WIDTH=1 the truth table SHALL be: 000->sum0 carry0; 001/010/100->sum1 carry0; 011/101/110->sum0 carry1; 111->sum1 carry1 (order a,b,c).
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N with in_valid=1 appear on sum/carry after edge N, with out_valid=1.
REQ-015 When in_valid=0 at an edge, sum and carry SHALL hold their previous values and out_valid SHALL go to 0.
REQ-016 No backpressure: every qualified input produces a result; back-to-back in_valid=1 yields one result per cycle.
REQ-017 Wrap-around: all-ones a and b with c=1 SHALL give sum all-ones, carry=1; all-ones a, b=0, c=1 SHALL give sum=0, carry=1.
REQ-018 Outputs SHALL be glitch-free registered values; no combinational path from inputs to outputs.
REQ-019 X/Z on inputs while in_valid=0 SHALL NOT affect outputs.

Reset
REQ-020 While rst=1 at a rising edge, sum SHALL become 0, carry 0, out_valid 0, regardless of in_valid.
REQ-021 Reset SHALL take priority over a simultaneous in_valid=1; that input is discarded.
REQ-022 The first edge with rst=0 and in_valid=1 SHALL produce a valid result one cycle later; no extra warm-up cycles.
REQ-023 Reset asserted mid-stream SHALL cancel any result not yet presented; no stale result after deassertion.

Structure
REQ-024 A shared package full_adder_pkg SHALL hold the default-width constant and the WIDTH range limits.
REQ-025 One sub-module fa_bit (1-bit a, b, cin -> s, cout, purely combinational) SHALL be instantiated WIDTH times in a ripple chain via a generate loop.
REQ-026 full_adder SHALL contain only the ripple chain, the output/valid registers and a parameter range check that fails elaboration outside 1..64.

Verification
REQ-027 WIDTH=1, in_valid=1, sequence (a,b,c)=000,001,010,111,110,101 -> next-cycle (sum,carry)=00,10,10,11,01,01, out_valid=1 each.
REQ-028 WIDTH=1 exhaustive 8 combinations back-to-back -> results match REQ-013 in order, one per cycle.
REQ-029 WIDTH=8, a=8'hFF, b=8'h01, c=0 -> sum=8'h00, carry=1; a=8'hFF, b=8'hFF, c=1 -> sum=8'hFF, carry=1.
REQ-030 Drive a=1,b=1,c=1 with in_valid=1 and rst=1 same edge -> sum=0, carry=0, out_valid=0 next cycle.
REQ-031 After a result, in_valid=0 for 3 cycles with changing inputs -> sum/carry unchanged, out_valid=0.
REQ-032 WIDTH=16, 1000 random vectors -> {carry,sum} equals a+b+c one cycle later.
